muxn_reg_scan: RTL



---
 rtl/muxn_reg_scan.sv | 124 ++++++++++++
 1 files changed

// File: rtl/muxn_reg_scan.sv
// Registered N-channel mux with a direct-select mode and a round-robin scan mode.
// Every output is registered, and asynchronous active-low reset clears all state.
module muxn_reg_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4,
    parameter int CNTW  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NCH*WIDTH-1:0] i_d,
    input  logic [SELW-1:0]      i_sel,
    input  logic                 i_mode,
    input  logic                 i_en,
    output logic [WIDTH-1:0]     o_y,
    output logic [SELW-1:0]      o_ch,
    output logic                 o_valid,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);

    state_t            state;
    state_t            state_nx;
    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   ptr_nx;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_nx;
    logic [WIDTH-1:0]  y_nx;
    logic [SELW-1:0]   ch_nx;
    logic              valid_nx;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  ptr_data;
    logic              sel_legal;

    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Mode changes act on the edge that samples them, so outputs key off state_nx.
    always_comb begin
        state_nx = IDLE;
        if (i_en) begin
            state_nx = i_mode ? SCAN : DIRECT;
        end
    end

    // Decoded per-channel muxes; an out-of-range select simply finds no match.
    always_comb begin
        sel_data  = '0;
        sel_legal = 1'b0;
        ptr_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (i_sel == SELW'(k)) begin
                sel_data  = i_d[k*WIDTH +: WIDTH];
                sel_legal = 1'b1;
            end
            if (ptr == SELW'(k)) begin
                ptr_data = i_d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        y_nx     = o_y;
        ch_nx    = o_ch;
        valid_nx = 1'b0;
        ptr_nx   = '0;
        cnt_nx   = '0;
        case (state_nx)
            DIRECT: begin
                ch_nx    = i_sel;
                y_nx     = sel_legal ? sel_data : '0;
                valid_nx = sel_legal;
            end
            SCAN: begin
                // ptr/cnt are already zero on entry because every other state clears them.
                y_nx     = ptr_data;
                ch_nx    = ptr;
                valid_nx = 1'b1;
                if (cnt == LAST_CNT) begin
                    cnt_nx = '0;
                    ptr_nx = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    ptr_nx = ptr;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_y     <= '0;
            o_ch    <= '0;
            o_valid <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            o_y     <= y_nx;
            o_ch    <= ch_nx;
            o_valid <= valid_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
        end
    end

endmodule
